// File: rtl/cpu6_mem_lsu_if.sv
// Data-bus bundle between the cpu6 load/store unit (master) and the data memory (slave).
// Latency: none, wires only.
// Backpressure: master holds dbus_req and its qualifiers until dbus_gnt; one dbus_rvalid per grant.
// Signals: dbus_req/we/addr/be/wdata master->slave; dbus_gnt/rvalid/rdata slave->master.
interface cpu6_mem_lsu_if #(
    parameter int XLEN = 32
);
    logic            dbus_req;
    logic            dbus_we;
    logic [XLEN-1:0] dbus_addr;
    logic [3:0]      dbus_be;
    logic [XLEN-1:0] dbus_wdata;
    logic            dbus_gnt;
    logic            dbus_rvalid;
    logic [XLEN-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/cpu6_mem_lsu.sv
// M-stage load/store unit: runs one request/grant/response data-bus access per load/store, extends load data.
// Latency: 3 cycles minimum per memory op (request, response, DONE); non-memory ops pass through in 0 cycles.
// Backpressure: stallM stays high until the access retires; in REQ the request is held stable until dbus_gnt.
// Ports: clk/reset (async active-low); M-stage controls in; dbus via cpu6_mem_lsu_if.master;
//        readdataM/resultM/stallM/bus_errM out. XLEN must be 32.
// Optional: define CPU6_LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses (default: forced alignment).
module cpu6_mem_lsu #(
    parameter int XLEN         = 32,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwriteM,
    input  logic              memtoregM,
    input  logic [2:0]        funct3M,
    input  logic [XLEN-1:0]   aluout_typeuimmM,
    input  logic [XLEN-1:0]   writedataM,
    input  logic [XLEN-1:0]   pcplus4M,
    input  logic              jumpM,
    input  logic              flashM,
    cpu6_mem_lsu_if.master    dbus,
    output logic [XLEN-1:0]   readdataM,
    output logic [XLEN-1:0]   resultM,
    output logic              stallM,
    output logic              bus_errM
);
    localparam int CW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] readdata_q, readdata_d;
    logic            bus_err_q, bus_err_d;

    logic            memop;
    logic            trap;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ld_ext;
    logic [CW-1:0]   cnt_inc;

    logic            req_c, we_c;
    logic [XLEN-1:0] addr_c, wdata_o;
    logic [3:0]      be_o;

    assign memop = (memwriteM | memtoregM) & ~flashM;

`ifdef CPU6_LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((funct3M[1:0] == 2'b01) & aluout_typeuimmM[0])
                    | (funct3M[1] & (aluout_typeuimmM[1:0] != 2'b00));
    // A trapped access never reaches the bus; the error is flagged in the IDLE cycle itself.
    assign trap = memop & misalign & (state_q == IDLE);
`else
    assign trap = 1'b0;
`endif

    // Byte enables and lane replication come straight from the M-stage inputs so a
    // same-cycle grant in IDLE sees a complete request.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = writedataM;
        case (funct3M[1:0])
            2'b00: begin
                be_c    = 4'b0001 << aluout_typeuimmM[1:0];
                wdata_c = {4{writedataM[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {aluout_typeuimmM[1], 1'b0};
                wdata_c = {2{writedataM[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction uses the captured address/size, not the live pipeline inputs.
    always_comb begin
        byte_sel = 8'(dbus.dbus_rdata >> {addr_q[1:0], 3'b000});
        half_sel = 16'(dbus.dbus_rdata >> {addr_q[1], 4'b0000});
        case (funct3_q)
            3'b000:  ld_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  ld_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, half_sel};
            default: ld_ext = dbus.dbus_rdata;
        endcase
    end

    // Bus drive: combinational from inputs in IDLE, from capture registers in REQ, quiet otherwise.
    always_comb begin
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        be_o    = 4'b0000;
        wdata_o = '0;
        case (state_q)
            IDLE: if (memop && !trap) begin
                req_c   = 1'b1;
                we_c    = memwriteM;
                addr_c  = {aluout_typeuimmM[XLEN-1:2], 2'b00};
                be_o    = be_c;
                wdata_o = wdata_c;
            end
            REQ: begin
                req_c   = 1'b1;
                we_c    = we_q;
                addr_c  = {addr_q[XLEN-1:2], 2'b00};
                be_o    = be_q;
                wdata_o = wdata_q;
            end
            default: ;
        endcase
    end

    assign dbus.dbus_req   = req_c;
    assign dbus.dbus_we    = we_c;
    assign dbus.dbus_addr  = addr_c;
    assign dbus.dbus_be    = be_o;
    assign dbus.dbus_wdata = wdata_o;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        bus_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap) begin
                    state_d    = DONE;
                    readdata_d = '0;
                end else if (memop) begin
                    addr_d   = aluout_typeuimmM;
                    we_d     = memwriteM;
                    be_d     = be_c;
                    wdata_d  = wdata_c;
                    funct3_d = funct3M;
                    cnt_d    = '0;
                    state_d  = dbus.dbus_gnt ? RESP : REQ;
                end
            end
            REQ: if (dbus.dbus_gnt) state_d = RESP;
            RESP: begin
                // Flush does not cancel here: the granted access must still retire on the bus.
                cnt_d = cnt_inc;
                if (dbus.dbus_rvalid) begin
                    readdata_d = ld_ext;
                    state_d    = DONE;
                end else if (RESP_TIMEOUT != 0 && cnt_inc == CW'(RESP_TIMEOUT)) begin
                    bus_err_d  = 1'b1;
                    readdata_d = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            funct3_q   <= 3'b000;
            cnt_q      <= '0;
            readdata_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign readdataM = readdata_q;
    assign bus_errM  = bus_err_q | trap;
    assign resultM   = jumpM ? pcplus4M : aluout_typeuimmM;
    // DONE drops the stall for one cycle even though the memory op is still presented.
    assign stallM    = (memop & (state_q != DONE)) | (state_q == REQ) | (state_q == RESP);
endmodule

// File: tb/tb_cpu6_mem_lsu.sv
// Testbench for cpu6_mem_lsu: acts as pipeline driver and data-bus slave, checks against a reference model.
// Latency: n/a. Backpressure: grant and response delays are randomized by the bench.
module tb_cpu6_mem_lsu;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwriteM, memtoregM, jumpM, flashM;
    logic [2:0]  funct3M;
    logic [31:0] aluout_typeuimmM, writedataM, pcplus4M;
    logic [31:0] readdataM, resultM;
    logic        stallM, bus_errM;

    cpu6_mem_lsu_if #(.XLEN(32)) dbus ();

    cpu6_mem_lsu #(.XLEN(32), .RESP_TIMEOUT(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .memwriteM        (memwriteM),
        .memtoregM        (memtoregM),
        .funct3M          (funct3M),
        .aluout_typeuimmM (aluout_typeuimmM),
        .writedataM       (writedataM),
        .pcplus4M         (pcplus4M),
        .jumpM            (jumpM),
        .flashM           (flashM),
        .dbus             (dbus),
        .readdataM        (readdataM),
        .resultM          (resultM),
        .stallM           (stallM),
        .bus_errM         (bus_errM)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference rules, written as plain arithmetic.
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] be_model(input logic [2:0] f3, input logic [31:0] a);
        case (f3 % 4)
            0:       return 32'd1 << (a % 4);
            1:       return 32'd3 << (a & 32'd2);
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] wd);
        case (f3 % 4)
            0:       return (wd & 32'hFF) * 32'h01010101;
            1:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    // One memory op: gd = grant delay in REQ cycles, rd = RESP cycles before rvalid (-1: never, timeout).
    task automatic do_mem(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int gd, input int rd, input logic [31:0] rdat, input bit fl);
        bit          trap;
        int          n;
        logic [31:0] exp_rd;
        trap = 1'b0;
`ifdef CPU6_LSU_MISALIGN_TRAP_EN
        trap = ((f3 % 4) == 1 && a[0]) || (f3[1] && (a % 4) != 0);
`endif
        memwriteM = st; memtoregM = !st; funct3M = f3; aluout_typeuimmM = a;
        writedataM = wd; pcplus4M = $urandom; jumpM = 1'b0; flashM = 1'b0;
        dbus.dbus_gnt = (gd == 0); dbus.dbus_rvalid = 1'b0; dbus.dbus_rdata = $urandom;
        #3;
        check("idle_stall", stallM, 1);
        check("idle_result", resultM, a);
        if (trap) begin
            check("trap_req", dbus.dbus_req, 0);
            check("trap_err", bus_errM, 1);
            next_cyc();
            #3;
            check("trap_done_stall", stallM, 0);
            check("trap_done_rd", readdataM, 0);
            next_cyc();
            return;
        end
        check("idle_req", dbus.dbus_req, 1);
        check("idle_we", dbus.dbus_we, st);
        check("idle_addr", dbus.dbus_addr, a & ~32'd3);
        check("idle_be", dbus.dbus_be, be_model(f3, a));
        if (st) check("idle_wdata", dbus.dbus_wdata, wdata_model(f3, wd));
        next_cyc();
        for (int k = 1; k <= gd; k++) begin
            flashM = fl;
            dbus.dbus_gnt = (k == gd);
            #3;
            check("req_req", dbus.dbus_req, 1);
            check("req_stall", stallM, 1);
            check("req_addr", dbus.dbus_addr, a & ~32'd3);
            check("req_be", dbus.dbus_be, be_model(f3, a));
            check("req_we", dbus.dbus_we, st);
            if (st) check("req_wdata", dbus.dbus_wdata, wdata_model(f3, wd));
            next_cyc();
        end
        dbus.dbus_gnt = 1'b0;
        n = (rd < 0) ? TMO : rd + 1;
        for (int k = 1; k <= n; k++) begin
            flashM = fl;
            dbus.dbus_rvalid = (rd >= 0 && k == n);
            dbus.dbus_rdata = dbus.dbus_rvalid ? rdat : $urandom;
            #3;
            check("resp_req", dbus.dbus_req, 0);
            check("resp_stall", stallM, 1);
            check("resp_err", bus_errM, 0);
            next_cyc();
        end
        dbus.dbus_rvalid = 1'b0;
        exp_rd = (rd < 0) ? 32'd0 : load_model(f3, a, rdat);
        #3;
        check("done_stall", stallM, 0);
        check("done_err", bus_errM, (rd < 0) ? 1 : 0);
        if (!st || rd < 0) check("done_rdata", readdataM, exp_rd);
        next_cyc();
    endtask

    task automatic do_nonmem();
        logic [31:0] a, p;
        logic        j;
        a = $urandom; p = $urandom; j = 1'($urandom_range(0, 1));
        memwriteM = 1'b0; memtoregM = 1'b0; flashM = 1'($urandom_range(0, 1));
        aluout_typeuimmM = a; pcplus4M = p; jumpM = j; funct3M = 3'($urandom);
        dbus.dbus_gnt = 1'($urandom_range(0, 1)); dbus.dbus_rvalid = 1'b0;
        #3;
        check("nm_stall", stallM, 0);
        check("nm_req", dbus.dbus_req, 0);
        check("nm_result", resultM, j ? p : a);
        next_cyc();
    endtask

    task automatic do_flush_idle();
        memwriteM = 1'($urandom_range(0, 1)); memtoregM = !memwriteM; flashM = 1'b1;
        aluout_typeuimmM = $urandom; funct3M = 3'b010; jumpM = 1'b0;
        dbus.dbus_gnt = 1'b1; dbus.dbus_rvalid = 1'b0;
        #3;
        check("fl_req", dbus.dbus_req, 0);
        check("fl_stall", stallM, 0);
        next_cyc();
    endtask

    task automatic reset_mid();
        memwriteM = 1'b0; memtoregM = 1'b1; funct3M = 3'b010; aluout_typeuimmM = 32'h200;
        flashM = 1'b0; jumpM = 1'b0; dbus.dbus_gnt = 1'b1; dbus.dbus_rvalid = 1'b0;
        next_cyc();
        dbus.dbus_gnt = 1'b0; memtoregM = 1'b0;
        reset = 1'b0;
        #3;
        check("rst_stall", stallM, 0);
        check("rst_req", dbus.dbus_req, 0);
        check("rst_rdata", readdataM, 0);
        reset = 1'b1;
        next_cyc();
        dbus.dbus_rvalid = 1'b1; dbus.dbus_rdata = 32'hCAFEF00D;
        #3;
        check("stale_stall", stallM, 0);
        next_cyc();
        dbus.dbus_rvalid = 1'b0;
        #3;
        check("stale_rdata", readdataM, 0);
        next_cyc();
    endtask

    initial begin
        bit          st;
        logic [2:0]  f3;
        int          kind, rd;
        logic [2:0]  ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        reset = 1'b0;
        memwriteM = 1'b0; memtoregM = 1'b0; funct3M = 3'b0; jumpM = 1'b0; flashM = 1'b0;
        aluout_typeuimmM = 32'h0; writedataM = 32'h0; pcplus4M = 32'h0;
        dbus.dbus_gnt = 1'b0; dbus.dbus_rvalid = 1'b0; dbus.dbus_rdata = 32'h0;
        #3;
        check("rst_rd", readdataM, 0);
        check("rst_err", bus_errM, 0);
        check("rst_stall0", stallM, 0);
        check("rst_req0", dbus.dbus_req, 0);
        check("rst_we0", dbus.dbus_we, 0);
        check("rst_addr0", dbus.dbus_addr, 0);
        check("rst_be0", dbus.dbus_be, 0);
        check("rst_wdata0", dbus.dbus_wdata, 0);
        next_cyc();
        reset = 1'b1;

        do_mem(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
        do_mem(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80AABBCC, 1'b0);
        do_mem(1'b0, 3'b100, 32'h103, 32'h0, 1, 1, 32'h80AABBCC, 1'b0);
        do_mem(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 3, 0, 32'h0, 1'b0);
        do_mem(1'b0, 3'b010, 32'h40, 32'h0, 0, -1, 32'h0, 1'b0);
        do_mem(1'b0, 3'b001, 32'h2, 32'h0, 2, 2, 32'h8001_7FFF, 1'b1);
        do_flush_idle();
        do_mem(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h11223344, 1'b0);
        reset_mid();
        do_mem(1'b0, 3'b101, 32'h302, 32'h0, 0, 1, 32'hFEDC1234, 1'b0);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                do_nonmem();
            end else if (kind == 2) begin
                do_flush_idle();
            end else begin
                st = ($urandom_range(0, 2) == 0);
                f3 = st ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
                rd = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 2);
                do_mem(st, f3, $urandom, $urandom, $urandom_range(0, 3), rd, $urandom,
                       ($urandom_range(0, 3) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cpu6_mem_lsu.md
Name: cpu6_mem_lsu

Overview:
- Memory-stage load/store unit for cpu6. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Consumes the M-stage controls: memwrite, memtoreg, address (aluout_typeuimm), write data, pcplus4 and jump.
- Runs a request/grant/response transaction on the data bus and holds the pipeline with a stall until the access completes.
- Produces the sign/zero-extended load data and the M-stage result for writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESP_TIMEOUT, 255, maximum cycles in RESP before a bus error is raised; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- memwriteM  in  1  store in M.
- memtoregM  in  1  load in M.
- funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- aluout_typeuimmM  in  XLEN  effective address, or non-memory result.
- writedataM  in  XLEN  store data (rs2).
- pcplus4M  in  XLEN  link value.
- jumpM  in  1  selects pcplus4M as the result.
- flashM  in  1  flush of the M-stage instruction.
- dbus_req  out  1  bus request.
- dbus_we  out  1  write request.
- dbus_addr  out  XLEN  word-aligned address.
- dbus_be  out  4  byte enables.
- dbus_wdata  out  XLEN  lane-replicated store data.
- dbus_gnt  in  1  request accepted.
- dbus_rvalid  in  1  response valid; one per granted request, for both loads and stores.
- dbus_rdata  in  XLEN  read data.
- readdataM  out  XLEN  extended load data.
- resultM  out  XLEN  jumpM ? pcplus4M : aluout_typeuimmM (combinational).
- stallM  out  1  freeze F/D/E/M stages and the EX/MEM register.
- bus_errM  out  1  one-cycle pulse on timeout (or on a misaligned access, see Optional Feature).

Behaviour:
- memop = (memwriteM | memtoregM) & ~flashM.
- FSM states: IDLE, REQ, RESP, DONE. Reset: state = IDLE; readdataM = 0; bus_errM = 0; timeout counter = 0; all dbus outputs 0.
- IDLE:
  - dbus_req = memop (combinational).
  - memop & dbus_gnt -> RESP.
  - memop & ~dbus_gnt -> REQ.
- REQ:
  - dbus_req = 1; address, we, be and wdata come from registers captured at IDLE exit and are stable until grant.
  - dbus_gnt -> RESP.
- RESP:
  - dbus_req = 0. Counter increments each cycle.
  - dbus_rvalid -> latch the extended rdata into readdataM, go to DONE.
  - counter == RESP_TIMEOUT (when nonzero) -> pulse bus_errM, go to DONE, readdataM = 0.
- DONE:
  - stallM = 0 for exactly one cycle so the pipeline advances; then IDLE. The counter clears on DONE.
- stallM = memop & (state != DONE) | (state == REQ) | (state == RESP).
- Minimum load/store occupancy is 3 cycles: gnt in the request cycle, rvalid in the next cycle, then DONE.
- Byte enables:
  - SB: 0001 << addr[1:0].
  - SH: 0011 << {addr[1],0}.
  - SW: 1111.
- Write data: SB lane-replicated {4{wd[7:0]}}; SH {2{wd[15:0]}}; SW as is.
- dbus_addr = {addr[XLEN-1:2], 2'b00}.
- Load extract: byte/half selected by addr[1:0]/addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Flush mid-transaction: flashM in REQ or RESP does not cancel an accepted or pending request. The bus transaction completes, readdataM is updated, and DONE still occurs; writeback suppression is the MEM/WB register's job.
- flashM in IDLE prevents a new request.
- Non-memory instructions: stallM = 0, no bus activity, resultM passes through.
- Async reset mid-transaction returns to IDLE immediately; an outstanding response is ignored, and dbus_rvalid in IDLE is dropped.

Optional Feature:
- CPU6_LSU_MISALIGN_TRAP_EN defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus request.
  - bus_errM pulses in the IDLE cycle, the FSM goes directly to DONE (stallM=1 that cycle), and readdataM = 0.
- Undefined: low address bits are silently ignored for misaligned halfword/word accesses (forced alignment); no trap.

Test Plan:
- LW at 0x100, gnt same cycle, rvalid next with 0xDEADBEEF -> readdataM=0xDEADBEEF, stallM high 2 cycles then low 1; dbus_be=1111.
- LB at 0x103, rdata 0x80AABBCC -> readdataM=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x102, writedata 0x1234ABCD, gnt delayed 3 cycles -> dbus_be=1100, dbus_wdata=0xABCDABCD, addr=0x100, held stable in REQ until gnt.
- RESP_TIMEOUT=4, no rvalid -> bus_errM pulses 1 cycle after 4 RESP cycles; FSM passes through DONE to IDLE.
- flashM asserted in RESP -> transaction still completes on rvalid; flashM asserted in IDLE with memtoregM=1 -> dbus_req stays 0, stallM=0.
- With CPU6_LSU_MISALIGN_TRAP_EN, LW at 0x102 -> no dbus_req, bus_errM=1; without the macro -> dbus_addr=0x100, normal load.
